pl_led_axi_ctrl: RTL and testbench



---
 rtl/pl_led_axi_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_pl_led_axi_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_led_axi_ctrl.sv
// AXI3 slave on PS7 GP0 driving the 8 board LEDs from a small register bank.
// Handles single-beat register writes and reads; bursts are drained and answered with SLVERR.
module pl_led_axi_ctrl #(
    parameter int          ID_W       = 12,
    parameter int          PRESCALE_W = 24,
    parameter logic [31:0] ID_VALUE   = 32'h1ED0_0001
) (
    input  logic            i_clk0,
    input  logic            i_rst,
    input  logic [ID_W-1:0] i_awid,
    input  logic [31:0]     i_awaddr,
    input  logic [3:0]      i_awlen,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [31:0]     i_wdata,
    input  logic [3:0]      i_wstrb,
    input  logic            i_wlast,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [ID_W-1:0] o_bid,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    input  logic [ID_W-1:0] i_arid,
    input  logic [31:0]     i_araddr,
    input  logic [3:0]      i_arlen,
    input  logic            i_arvalid,
    output logic            o_arready,
    output logic [ID_W-1:0] o_rid,
    output logic [31:0]     o_rdata,
    output logic [1:0]      o_rresp,
    output logic            o_rlast,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [7:0]      o_led
);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_COLLECT   = 2'd1;
    localparam logic [1:0] W_DRAIN     = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;
    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  r_en;
    logic [1:0]            r_wstate;
    logic                  r_aw_held;
    logic [1:0]            r_aw_sel;
    logic [3:0]            r_awlen;
    logic [ID_W-1:0]       r_awid;
    logic                  r_w_held;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_wlast;
    logic [1:0]            r_bresp;
    logic [0:0]            r_rstate;
    logic [ID_W-1:0]       r_rid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic [3:0]            r_rleft;
    logic [7:0]            r_led;
    logic [1:0]            r_mode;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;

    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_b_fire;
    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic                  w_commit;
    logic                  w_tick;
    logic [31:0]           w_ps_merged;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    // NOTE: readies are gated by r_en so every output is 0 in the cycle after reset.
    assign o_awready = r_en && !r_aw_held && (r_wstate != W_RESP);
    assign o_wready  = r_en && (!r_w_held || (r_wstate == W_DRAIN));
    assign o_bvalid  = (r_wstate == W_RESP);
    assign o_bresp   = r_bresp;
    assign o_bid     = r_awid;
    assign o_arready = r_en && (r_rstate == R_IDLE);
    assign o_rvalid  = (r_rstate == R_DATA);
    assign o_rlast   = o_rvalid && (r_rleft == 4'd0);
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_led     = r_led;

    assign w_aw_fire = i_awvalid && o_awready;
    assign w_w_fire  = i_wvalid && o_wready;
    assign w_b_fire  = o_bvalid && i_bready;
    assign w_ar_fire = i_arvalid && o_arready;
    assign w_r_fire  = o_rvalid && i_rready;
    assign w_commit  = ((r_wstate == W_IDLE) || (r_wstate == W_COLLECT)) &&
                       r_aw_held && r_w_held && (r_awlen == 4'd0);
    assign w_tick    = (r_pcnt == r_prescale);
    assign w_unused  = ^{i_awaddr[31:4], i_awaddr[1:0], i_araddr[31:4], i_araddr[1:0]};

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        w_ps_merged = 32'(r_prescale);
        for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) w_ps_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (i_araddr[3:2])
            2'd0:    w_rd_val[7:0]            = r_led;
            2'd1:    w_rd_val[1:0]            = r_mode;
            2'd2:    w_rd_val[PRESCALE_W-1:0] = r_prescale;
            default: w_rd_val                 = ID_VALUE;
        endcase
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) r_en <= 1'b0;
        else       r_en <= 1'b1;
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_aw_sel  <= 2'd0;
            r_awlen   <= 4'd0;
            r_awid    <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_wlast   <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_sel  <= i_awaddr[3:2];
                r_awlen   <= i_awlen;
                r_awid    <= i_awid;
            end
            if (w_w_fire && (r_wstate != W_DRAIN)) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
                r_wlast  <= i_wlast;
            end
            case (r_wstate)
                W_IDLE, W_COLLECT: begin
                    if (r_aw_held && r_w_held) begin
                        r_w_held <= 1'b0;
                        if (r_awlen == 4'd0 || r_wlast) begin
                            r_bresp   <= (r_awlen == 4'd0) ? RESP_OKAY : RESP_SLVERR;
                            r_aw_held <= 1'b0;
                            r_wstate  <= W_RESP;
                        end else begin
                            r_wstate <= W_DRAIN;
                        end
                    end else if (r_aw_held || r_w_held || w_aw_fire || w_w_fire) begin
                        r_wstate <= W_COLLECT;
                    end
                end
                W_DRAIN: begin
                    if (w_w_fire && i_wlast) begin
                        r_bresp   <= RESP_SLVERR;
                        r_aw_held <= 1'b0;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_fire) r_wstate <= (r_w_held || w_w_fire) ? W_COLLECT : W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // A committed LED write is assigned after the tick update so software wins.
    always_ff @(posedge i_clk0) begin
        if (i_rst) begin
            r_led      <= 8'd0;
            r_mode     <= 2'd0;
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                case (r_mode)
                    2'd1:    r_led <= r_led + 8'd1;
                    2'd2:    r_led <= {r_led[6:0], r_led[7]};
                    default: r_led <= r_led;
                endcase
            end
            if (w_commit) begin
                case (r_aw_sel)
                    2'd0: if (r_wstrb[0]) r_led <= r_wdata[7:0];
                    2'd1: if (r_wstrb[0]) r_mode <= r_wdata[1:0];
                    2'd2: begin
                        r_prescale <= w_ps_merged[PRESCALE_W-1:0];
                        r_pcnt     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
            r_rleft  <= 4'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rstate <= R_DATA;
                        r_rid    <= i_arid;
                        r_rleft  <= i_arlen;
                        r_rdata  <= (i_arlen == 4'd0) ? w_rd_val : 32'd0;
                        r_rresp  <= (i_arlen == 4'd0) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (w_r_fire) begin
                        if (r_rleft == 4'd0) r_rstate <= R_IDLE;
                        else                 r_rleft  <= r_rleft - 4'd1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_led_axi_ctrl.sv
// Self-checking bench for pl_led_axi_ctrl: directed AXI transactions plus a
// cycle-level LED model compared on every falling edge.
module tb_pl_led_axi_ctrl;

    localparam int ID_W = 12;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            i_clk0 = 1'b0;
    logic            i_rst;
    logic [ID_W-1:0] i_awid;
    logic [31:0]     i_awaddr;
    logic [3:0]      i_awlen;
    logic            i_awvalid;
    logic            o_awready;
    logic [31:0]     i_wdata;
    logic [3:0]      i_wstrb;
    logic            i_wlast;
    logic            i_wvalid;
    logic            o_wready;
    logic [ID_W-1:0] o_bid;
    logic [1:0]      o_bresp;
    logic            o_bvalid;
    logic            i_bready;
    logic [ID_W-1:0] i_arid;
    logic [31:0]     i_araddr;
    logic [3:0]      i_arlen;
    logic            i_arvalid;
    logic            o_arready;
    logic [ID_W-1:0] o_rid;
    logic [31:0]     o_rdata;
    logic [1:0]      o_rresp;
    logic            o_rlast;
    logic            o_rvalid;
    logic            i_rready;
    logic [7:0]      o_led;

    always #5 i_clk0 = ~i_clk0;

    pl_led_axi_ctrl dut (
        .i_clk0(i_clk0), .i_rst(i_rst),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
        .i_rready(i_rready), .o_led(o_led)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // LED model: ticks every PRESCALE+1 cycles counted from the last clear.
    logic [7:0]  m_led;
    logic [1:0]  m_mode;
    logic [23:0] m_prescale;
    longint      m_since;
    bit          m_tick;
    bit          m_wr_pend = 1'b0;
    logic [31:0] m_wr_addr, m_wr_data;
    logic [3:0]  m_wr_strb;

    always @(posedge i_clk0) begin
        if (i_rst) begin
            m_led = 8'd0; m_mode = 2'd0; m_prescale = 24'd0; m_since = 0; m_wr_pend = 1'b0;
        end else begin
            m_tick = (m_since % (longint'(m_prescale) + 1)) == longint'(m_prescale);
            m_since++;
            if (m_tick && m_mode == 2'd1) m_led = 8'((int'(m_led) + 1) % 256);
            if (m_tick && m_mode == 2'd2) m_led = 8'((int'(m_led) * 2) % 256 + int'(m_led) / 128);
            if (m_wr_pend) begin
                m_wr_pend = 1'b0;
                case (m_wr_addr[3:2])
                    2'd0: if (m_wr_strb[0]) m_led = m_wr_data[7:0];
                    2'd1: if (m_wr_strb[0]) m_mode = m_wr_data[1:0];
                    2'd2: begin
                        for (int b = 0; b < 3; b++)
                            if (m_wr_strb[b]) m_prescale[b*8 +: 8] = m_wr_data[b*8 +: 8];
                        m_since = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge i_clk0) begin
        if (cmp_en) check("led_model", {24'd0, o_led}, {24'd0, m_led});
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast, o_bresp, o_rresp}, 32'd0);
        check({tag, "_led"}, {24'd0, o_led}, 32'd0);
        check({tag, "_rdata"}, o_rdata, 32'd0);
        check({tag, "_ids"}, {o_bid, o_rid}, 32'd0);
    endtask

    task automatic wait_b(input logic [ID_W-1:0] id, input logic [1:0] resp, input int bstall);
        for (int s = 0; s <= bstall; s++) begin
            check("bvalid", o_bvalid, 1);
            check("awready_in_resp", o_awready, 0);
            check("bresp", o_bresp, resp);
            check("bid", o_bid, id);
            if (s == bstall) i_bready = 1'b1;
            @(negedge i_clk0);
        end
        i_bready = 1'b0;
        check("bvalid_drop", o_bvalid, 0);
        check("awready_after_b", o_awready, 1);
    endtask

    task automatic wr_single(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [ID_W-1:0] id, input int w_lead, input int bstall);
        bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
        @(negedge i_clk0);
        i_awaddr = addr; i_awid = id; i_awlen = 4'd0;
        i_wdata = data; i_wstrb = strb; i_wlast = 1'b1; i_wvalid = 1'b1;
        for (int c = 0; c < 100 && !(aw_done && w_done); c++) begin
            if (c == w_lead && !aw_done) i_awvalid = 1'b1;
            check("b_early", o_bvalid, 0);
            if (w_done && !aw_done) check("wready_held_low", o_wready, 0);
            aw_fire = i_awvalid && o_awready;
            w_fire  = i_wvalid && o_wready;
            @(negedge i_clk0);
            if (aw_fire) begin i_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin i_wvalid = 1'b0; w_done = 1'b1; end
        end
        check("wr_handshakes", {31'd0, aw_done && w_done}, 1);
        if (aw_done && w_done) begin
            m_wr_addr = addr; m_wr_data = data; m_wr_strb = strb; m_wr_pend = 1'b1;
        end
        @(negedge i_clk0);
        wait_b(id, OKAY, bstall);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input logic [ID_W-1:0] id);
        bit done = 1'b0, aw_fire, w_fire;
        int beat = 0;
        @(negedge i_clk0);
        i_awaddr = addr; i_awid = id; i_awlen = len; i_awvalid = 1'b1;
        i_wdata = 32'hDEAD_0000; i_wstrb = 4'hF; i_wlast = (len == 4'd0); i_wvalid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            check("b_early_burst", o_bvalid, 0);
            aw_fire = i_awvalid && o_awready;
            w_fire  = i_wvalid && o_wready;
            @(negedge i_clk0);
            if (aw_fire) i_awvalid = 1'b0;
            if (w_fire) begin
                if (beat == int'(len)) begin
                    i_wvalid = 1'b0; i_wlast = 1'b0; done = 1'b1;
                end else begin
                    beat++;
                    i_wdata = 32'hDEAD_0000 | 32'(beat);
                    i_wlast = (beat == int'(len));
                end
            end
        end
        check("burst_beats_done", {31'd0, done}, 1);
        wait_b(id, SLVERR, 0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [3:0] len, input logic [ID_W-1:0] id,
                      input logic [31:0] exp_data, input int rstall);
        bit fired = 1'b0, f;
        int hold;
        @(negedge i_clk0);
        i_araddr = addr; i_arlen = len; i_arid = id; i_arvalid = 1'b1;
        for (int c = 0; c < 100 && !fired; c++) begin
            f = o_arready;
            @(negedge i_clk0);
            if (f) fired = 1'b1;
        end
        i_arvalid = 1'b0;
        check("ar_accepted", {31'd0, fired}, 1);
        for (int b = 0; b <= int'(len); b++) begin
            hold = (b == 0) ? rstall : 0;
            for (int s = 0; s <= hold; s++) begin
                check("rvalid", o_rvalid, 1);
                check("rid", o_rid, id);
                check("rresp", o_rresp, (len == 4'd0) ? OKAY : SLVERR);
                check("rdata", o_rdata, (len == 4'd0) ? exp_data : 32'd0);
                check("rlast", o_rlast, (b == int'(len)) ? 1 : 0);
                check("arready_busy", o_arready, 0);
                if (s == hold) i_rready = 1'b1;
                @(negedge i_clk0);
            end
            i_rready = 1'b0;
        end
        check("rvalid_drop", o_rvalid, 0);
        check("arready_after_r", o_arready, 1);
    endtask

    task automatic watch3(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input string tag);
        int t = 0, t1;
        logic [7:0] prev;
        while (o_led !== v0 && t < 60) begin @(negedge i_clk0); t++; end
        check({tag, "_start"}, {24'd0, o_led}, {24'd0, v0});
        prev = o_led;
        while (o_led === prev && t < 120) begin @(negedge i_clk0); t++; end
        check({tag, "_first"}, {24'd0, o_led}, {24'd0, v1});
        t1 = t; prev = o_led;
        while (o_led === prev && t < 180) begin @(negedge i_clk0); t++; end
        check({tag, "_second"}, {24'd0, o_led}, {24'd0, v2});
        check({tag, "_period"}, t - t1, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        repeat (3) @(negedge i_clk0);
        check_all_zero("reset");
        i_rst = 1'b0;
        cmp_en = 1'b1;

        // Simultaneous AW/W, then read it back.
        wr_single(32'h0, 32'hA5, 4'hF, 12'h123, 0, 0);
        check("led_after_write", {24'd0, o_led}, 32'hA5);
        rd(32'h0, 4'd0, 12'h045, 32'hA5, 0);

        // W leads AW by three cycles.
        wr_single(32'h0, 32'h5A, 4'hF, 12'h111, 3, 0);
        check("led_w_lead", {24'd0, o_led}, 32'h5A);

        // Byte strobes.
        wr_single(32'h0, 32'h3C, 4'b1110, 12'h222, 0, 0);
        check("led_strb_off", {24'd0, o_led}, 32'h5A);
        wr_single(32'h8, 32'hFF12_3456, 4'b0101, 12'h333, 0, 0);
        rd(32'h8, 4'd0, 12'h001, 32'h0012_0056, 0);
        rd(32'h4, 4'd0, 12'h002, 32'h0, 0);

        // Burst write and burst read are rejected.
        wr_burst(32'h0, 4'd3, 12'h7AB);
        check("led_after_burst", {24'd0, o_led}, 32'h5A);
        rd(32'h0, 4'd1, 12'h0F0, 32'h0, 0);

        // Back-pressure on B and R.
        wr_single(32'h0, 32'h77, 4'hF, 12'h444, 0, 5);
        rd(32'h0, 4'd0, 12'h555, 32'h77, 4);

        // Count mode.
        wr_single(32'h8, 32'h2, 4'hF, 12'h010, 0, 0);
        wr_single(32'h0, 32'hFE, 4'hF, 12'h011, 0, 0);
        fork
            wr_single(32'h4, 32'h1, 4'hF, 12'h012, 0, 0);
            watch3(8'hFE, 8'hFF, 8'h00, "count");
        join
        wr_single(32'h4, 32'h0, 4'hF, 12'h013, 0, 0);
        rd(32'h8, 4'd0, 12'h014, 32'h2, 0);

        // Rotate mode.
        wr_single(32'h0, 32'h81, 4'hF, 12'h020, 0, 0);
        fork
            wr_single(32'h4, 32'h2, 4'hF, 12'h021, 0, 0);
            watch3(8'h81, 8'h03, 8'h06, "rotate");
        join

        // Reset while draining a burst.
        @(negedge i_clk0);
        i_awaddr = 32'h0; i_awlen = 4'd3; i_awid = 12'h3C3; i_awvalid = 1'b1;
        i_wdata = 32'h1; i_wstrb = 4'hF; i_wlast = 1'b0; i_wvalid = 1'b1;
        @(negedge i_clk0);
        i_awvalid = 1'b0;
        repeat (2) @(negedge i_clk0);
        check("drain_wready", o_wready, 1);
        i_wvalid = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk0);
        check_all_zero("rst_drain");
        i_rst = 1'b0;

        // Reset while returning read data.
        @(negedge i_clk0);
        i_araddr = 32'h0; i_arlen = 4'd2; i_arid = 12'h0AA; i_arvalid = 1'b1;
        @(negedge i_clk0);
        i_arvalid = 1'b0;
        check("rdata_before_rst", o_rvalid, 1);
        i_rst = 1'b1;
        @(negedge i_clk0);
        check_all_zero("rst_read");
        i_rst = 1'b0;

        // ID register is read-only.
        wr_single(32'hC, 32'hFFFF_FFFF, 4'hF, 12'h0CC, 0, 0);
        rd(32'hC, 4'd0, 12'h0DD, 32'h1ED0_0001, 0);

        repeat (2) @(negedge i_clk0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
